axi_lite_uart_dbg_master: RTL

// - AXI4-Lite initiator driven by a byte stream: parses debug commands from the UART RX byte path and

---
 rtl/axi_lite_uart_dbg_master_pkg.sv | 29 ++
 rtl/axi_lite_uart_dbg_master_if.sv | 40 ++++
 rtl/axi_lite_uart_dbg_master.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_uart_dbg_master_pkg.sv
// Shared constants and types for the UART-driven AXI4-Lite debug master.
// Command bytes, status bytes, FSM state encoding and AXI response codes.
package axi_lite_uart_dbg_master_pkg;

  localparam logic [7:0] CMD_WRITE_c    = 8'h57;
  localparam logic [7:0] CMD_READ_c     = 8'h52;
  localparam logic [7:0] STAT_BADCMD_c  = 8'hEE;

  localparam logic [1:0] RESP_OKAY_c    = 2'b00;
  localparam logic [1:0] RESP_SLVERR_c  = 2'b10;
  localparam logic [1:0] RESP_DECERR_c  = 2'b11;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR    = 4'd1,
    ST_DATA    = 4'd2,
    ST_WR_REQ  = 4'd3,
    ST_WR_RESP = 4'd4,
    ST_RD_REQ  = 4'd5,
    ST_RD_RESP = 4'd6,
    ST_TX_STAT = 4'd7,
    ST_TX_DATA = 4'd8
  } dbg_state_e;

  function automatic logic [7:0] status_byte(input logic [1:0] resp);
    return {6'b000000, resp};
  endfunction

endpackage

// File: rtl/axi_lite_uart_dbg_master_if.sv
// AXI4-Lite channel bundle between the debug master and the crossbar slave port.
// The master modport drives requests; the slave modport drives readies and responses.
interface axi_lite_uart_dbg_master_if #(
  parameter int unsigned ADDR_BW = 32,
  parameter int unsigned DATA_BW = 32
) ();

  logic [ADDR_BW-1:0]   awaddr;
  logic [2:0]           awprot;
  logic                 awvalid;
  logic                 awready;
  logic [DATA_BW-1:0]   wdata;
  logic [DATA_BW/8-1:0] wstrb;
  logic                 wvalid;
  logic                 wready;
  logic [1:0]           bresp;
  logic                 bvalid;
  logic                 bready;
  logic [ADDR_BW-1:0]   araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;
  logic [DATA_BW-1:0]   rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_uart_dbg_master.sv
// Byte-stream debug master: parses 'W'/'R' frames from the UART RX path, issues one
// AXI4-Lite transaction at a time and streams status (plus read data) back on UART TX.
module axi_lite_uart_dbg_master
  import axi_lite_uart_dbg_master_pkg::*;
#(
  parameter int unsigned AXI_ADDR_BW_p  = 32,
  parameter int unsigned AXI_DATA_BW_p  = 32,
  parameter int unsigned IDLE_TIMEOUT_p = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    i_rx_data,
  input  logic                          i_rx_valid,
  output logic                          o_rx_ready,
  output logic [7:0]                    o_tx_data,
  output logic                          o_tx_valid,
  input  logic                          i_tx_ready,
  axi_lite_uart_dbg_master_if.master    axi
);

  localparam int unsigned TMO_BW_c = $clog2(IDLE_TIMEOUT_p + 1);
  localparam logic [TMO_BW_c-1:0] TMO_LAST_c = TMO_BW_c'(IDLE_TIMEOUT_p - 1);

  dbg_state_e               state_q;
  logic [31:0]              addr_q;
  logic [AXI_DATA_BW_p-1:0] data_q;
  logic [1:0]               byte_cnt_q;
  logic [TMO_BW_c-1:0]      tmo_q;
  logic                     rd_q;
  logic                     awvalid_q;
  logic                     wvalid_q;
  logic                     arvalid_q;
  logic                     bready_q;
  logic                     rready_q;
  logic                     rx_ready_q;
  logic                     tx_valid_q;
  logic [7:0]               tx_data_q;

  logic rx_fire_s;
  logic tx_fire_s;
  logic aw_fire_s;
  logic w_fire_s;
  logic b_fire_s;
  logic ar_fire_s;
  logic r_fire_s;

  assign rx_fire_s = i_rx_valid && rx_ready_q;
  assign tx_fire_s = tx_valid_q && i_tx_ready;
  assign aw_fire_s = awvalid_q && axi.awready;
  assign w_fire_s  = wvalid_q && axi.wready;
  assign b_fire_s  = bready_q && axi.bvalid;
  assign ar_fire_s = arvalid_q && axi.arready;
  assign r_fire_s  = rready_q && axi.rvalid;

  assign o_rx_ready  = rx_ready_q;
  assign o_tx_valid  = tx_valid_q;
  assign o_tx_data   = tx_data_q;
  assign axi.awaddr  = addr_q[AXI_ADDR_BW_p-1:0];
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = data_q;
  assign axi.wstrb   = 4'hF;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.araddr  = addr_q[AXI_ADDR_BW_p-1:0];
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  // Command parser, AXI sequencer and response serializer in one registered FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'h0000_0000;
      data_q     <= '0;
      byte_cnt_q <= 2'd0;
      tmo_q      <= '0;
      rd_q       <= 1'b0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      rready_q   <= 1'b0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rx_ready_q <= 1'b1;
          byte_cnt_q <= 2'd0;
          tmo_q      <= '0;
          if (rx_fire_s) begin
            if (i_rx_data == CMD_WRITE_c || i_rx_data == CMD_READ_c) begin
              rd_q    <= (i_rx_data == CMD_READ_c);
              state_q <= ST_ADDR;
            end else begin
              rd_q       <= 1'b0;
              rx_ready_q <= 1'b0;
              tx_valid_q <= 1'b1;
              tx_data_q  <= STAT_BADCMD_c;
              state_q    <= ST_TX_STAT;
            end
          end
        end
        ST_ADDR: begin
          if (rx_fire_s) begin
            addr_q     <= {i_rx_data, addr_q[31:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            tmo_q      <= '0;
            if (byte_cnt_q == 2'd3) begin
              if (rd_q) begin
                rx_ready_q <= 1'b0;
                arvalid_q  <= 1'b1;
                state_q    <= ST_RD_REQ;
              end else begin
                state_q <= ST_DATA;
              end
            end
          end else if (tmo_q == TMO_LAST_c) begin
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (rx_fire_s) begin
            data_q     <= {i_rx_data, data_q[AXI_DATA_BW_p-1:8]};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            tmo_q      <= '0;
            if (byte_cnt_q == 2'd3) begin
              rx_ready_q <= 1'b0;
              awvalid_q  <= 1'b1;
              wvalid_q   <= 1'b1;
              state_q    <= ST_WR_REQ;
            end
          end else if (tmo_q == TMO_LAST_c) begin
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        // AW and W retire independently; move on once neither is still pending.
        ST_WR_REQ: begin
          if (aw_fire_s) awvalid_q <= 1'b0;
          if (w_fire_s)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || aw_fire_s) && (!wvalid_q || w_fire_s)) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (b_fire_s) begin
            bready_q   <= 1'b0;
            tx_valid_q <= 1'b1;
            tx_data_q  <= status_byte(axi.bresp);
            state_q    <= ST_TX_STAT;
          end
        end
        ST_RD_REQ: begin
          if (ar_fire_s) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (r_fire_s) begin
            rready_q   <= 1'b0;
            data_q     <= axi.rdata;
            tx_valid_q <= 1'b1;
            tx_data_q  <= status_byte(axi.rresp);
            state_q    <= ST_TX_STAT;
          end
        end
        ST_TX_STAT: begin
          if (tx_fire_s) begin
            if (rd_q) begin
              tx_data_q  <= data_q[7:0];
              data_q     <= {8'h00, data_q[AXI_DATA_BW_p-1:8]};
              byte_cnt_q <= 2'd0;
              state_q    <= ST_TX_DATA;
            end else begin
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end
        end
        ST_TX_DATA: begin
          if (tx_fire_s) begin
            if (byte_cnt_q == 2'd3) begin
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              byte_cnt_q <= 2'd0;
              state_q    <= ST_IDLE;
            end else begin
              tx_data_q  <= data_q[7:0];
              data_q     <= {8'h00, data_q[AXI_DATA_BW_p-1:8]};
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end
        default: begin
          awvalid_q  <= 1'b0;
          wvalid_q   <= 1'b0;
          arvalid_q  <= 1'b0;
          bready_q   <= 1'b0;
          rready_q   <= 1'b0;
          tx_valid_q <= 1'b0;
          rx_ready_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
